// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_prefetch_unit_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory and decode-side handshake bundle of the prefetch unit.
interface if_prefetch_unit_if;
  import if_prefetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_pc;
  logic [ILEN-1:0] instr_data;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_pc, instr_data,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_pc, instr_data,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with occupancy count; flush dominates push and pop.
module if_prefetch_unit_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: reads are only meaningful while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: in-order word fetch, prefetch queue, redirect flush.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  if_prefetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_return_pc;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_discard;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_head;
  logic            w_req;
  logic            w_hs;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_target;

  assign w_target = word_align(i_redirect_pc);
  // Queue slots are reserved for in-flight words, so a return can never find the queue full.
  assign w_occ    = {1'b0, w_count} + (CW+1)'(r_outstanding);
  assign w_req    = i_reset && !i_redirect_valid
                    && (r_outstanding < OW'(MAX_OUTSTANDING))
                    && (w_occ < (CW+1)'(DEPTH));
  assign w_hs     = w_req && bus.imem_gnt;
  assign w_drop   = bus.imem_rvalid && (r_discard != '0);
  assign w_push   = bus.imem_rvalid && (r_discard == '0) && !i_redirect_valid;
  assign w_pop    = !w_empty && bus.instr_ready;

  if_prefetch_unit_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_data  ({r_return_pc, bus.imem_rdata}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fetch_pc    <= RESET_PC;
      r_return_pc   <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= r_outstanding + OW'(w_hs) - OW'(bus.imem_rvalid);
      if (i_redirect_valid) begin
        r_fetch_pc  <= w_target;
        r_return_pc <= w_target;
        // Every response still in flight after this cycle belongs to the old stream.
        r_discard   <= r_outstanding - OW'(bus.imem_rvalid);
      end else begin
        if (w_hs)   r_fetch_pc  <= r_fetch_pc + 32'd4;
        if (w_push) r_return_pc <= r_return_pc + 32'd4;
        if (w_drop) r_discard   <= r_discard - OW'(1);
      end
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = !w_empty;
  assign bus.instr_pc    = w_empty ? '0 : w_head.pc;
  assign bus.instr_data  = w_empty ? NOP_INSTR : w_head.instr;

  a_discard_le_outstanding: assert property (
    @(posedge i_clk) disable iff (!i_reset) r_discard <= r_outstanding);
  a_no_spurious_rvalid: assert property (
    @(posedge i_clk) disable iff (!i_reset) bus.imem_rvalid |-> (r_outstanding != '0));
  a_full_unused: assert property (
    @(posedge i_clk) disable iff (!i_reset) !(w_full && w_push && !w_pop));
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit against an address-level reference model.
module tb_if_prefetch_unit;
  import if_prefetch_unit_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct { logic [31:0] addr; bit stale; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc = '0;

  if_prefetch_unit_if bus();

  if_prefetch_unit #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_redirect_valid (redir_v),
    .i_redirect_pc    (redir_pc),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  flight_t     inflight[$];
  entry_t      q[$];
  logic [31:0] mem_q[$];
  logic [31:0] m_fetch;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_req();
    return rst_n && !redir_v && (inflight.size() < MAXO)
           && (q.size() + inflight.size() < DEPTH);
  endfunction

  task automatic check_outputs();
    check("req",   32'(bus.imem_req), 32'(exp_req()));
    check("addr",  bus.imem_addr, m_fetch);
    check("valid", 32'(bus.instr_valid), 32'(q.size() != 0));
    check("pc",    bus.instr_pc,   (q.size() != 0) ? q[0].pc   : 32'h0);
    check("data",  bus.instr_data, (q.size() != 0) ? q[0].data : NOP_INSTR);
  endtask

  // One clock: drive inputs, check outputs, advance the model. Entered and left at posedge+1.
  task automatic cycle(input int gp, input int rp, input int yp, input bit redir,
                       input logic [31:0] tgt);
    bit      gnt, rv, rdy, ereq;
    flight_t f;
    gnt = ($urandom_range(99) < gp);
    rv  = (mem_q.size() != 0) && ($urandom_range(99) < rp);
    rdy = ($urandom_range(99) < yp);
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? word_of(mem_q[0]) : $urandom;
    bus.instr_ready = rdy;
    redir_v  = redir;
    redir_pc = tgt;
    #2;
    check_outputs();
    check("inflight", 32'(inflight.size()), 32'(mem_q.size()));
    ereq = exp_req();
    if (rv && mem_q.size() != 0) void'(mem_q.pop_front());
    f = '{addr: 32'h0, stale: 1'b1};
    if (rv && inflight.size() != 0) f = inflight.pop_front();
    if (redir) begin
      q.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_fetch = {tgt[31:2], 2'b00};
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (rv && !f.stale) q.push_back('{pc: f.addr, data: word_of(f.addr)});
      if (ereq && gnt) begin
        inflight.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
    if (bus.imem_req && gnt) mem_q.push_back(bus.imem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    inflight.delete();
    mem_q.delete();
    m_fetch = RPC;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    redir_v  = 1'b0;
    redir_pc = '0;
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    #12;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // streaming with a 1-cycle memory
    repeat (12) cycle(100, 100, 100, 1'b0, '0);
    // decode stall fills the queue, then drains in order
    repeat (10) cycle(100, 100, 0, 1'b0, '0);
    repeat (8)  cycle(100, 100, 100, 1'b0, '0);
    // redirect with requests in flight
    repeat (2)  cycle(100, 0, 100, 1'b0, '0);
    cycle(100, 100, 100, 1'b1, 32'h0000_0100);
    repeat (8)  cycle(100, 100, 100, 1'b0, '0);
    // grant stall then redirect during stall
    repeat (5)  cycle(0, 100, 100, 1'b0, '0);
    cycle(0, 100, 100, 1'b1, 32'h0000_0040);
    repeat (6)  cycle(100, 100, 100, 1'b0, '0);
    // misaligned target and address wrap
    cycle(100, 100, 100, 1'b1, 32'h0000_0203);
    repeat (5)  cycle(100, 100, 100, 1'b0, '0);
    cycle(100, 100, 100, 1'b1, 32'hFFFF_FFF8);
    repeat (6)  cycle(100, 100, 100, 1'b0, '0);
    // back-to-back redirects
    repeat (2)  cycle(100, 0, 100, 1'b0, '0);
    cycle(100, 50, 100, 1'b1, 32'h0000_0300);
    cycle(100, 100, 100, 1'b1, 32'h0000_0400);
    repeat (6)  cycle(100, 100, 100, 1'b0, '0);
    // reset mid-burst with a partly filled queue
    repeat (3)  cycle(100, 100, 0, 1'b0, '0);
    reset_mid();
    repeat (8)  cycle(100, 100, 100, 1'b0, '0);
    // random traffic
    repeat (800) cycle(70, 60, 70, ($urandom_range(99) < 6), $urandom);
    repeat (20)  cycle(100, 100, 100, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
